// File: rtl/mode_seq_fsm.sv
// -----------------------------------------------------------------------------
// mode_seq_fsm
//   Mode sequencer. It steps through NUM_STATES modes under command control
//   (NEXT/PREV/JUMP/HOME). A lock flag freezes the mode. An idle counter
//   returns the sequencer to mode 0 after TIMEOUT cycles without a command.
//   A state register holding an unused encoding recovers to mode 0.
//
// Ports
//   clk          : clock, rising-edge active
//   rst          : synchronous active-high reset
//   cmd[2:0]     : command code (0 NOP,1 NEXT,2 PREV,3 JUMP,4 LOCK,5 UNLOCK,
//                  6 HOME,7 reserved), qualified by cmd_valid
//   cmd_valid    : command qualifier
//   jump_target  : destination mode for JUMP, sampled with cmd
//   out          : Moore output, current mode zero-extended to OUT_W
//   state        : current mode register
//   locked       : lock flag
//   err          : one-cycle pulse for a rejected command or illegal-state recovery
//   timeout      : one-cycle pulse for an idle auto-return to mode 0
// -----------------------------------------------------------------------------
module mode_seq_fsm #(
  parameter int STATE_W    = 2,
  parameter int NUM_STATES = 4,
  parameter int OUT_W      = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         cmd,
  input  logic               cmd_valid,
  input  logic [STATE_W-1:0] jump_target,
  output logic [OUT_W-1:0]   out,
  output logic [STATE_W-1:0] state,
  output logic               locked,
  output logic               err,
  output logic               timeout
);

  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_NEXT   = 3'd1;
  localparam logic [2:0] CMD_PREV   = 3'd2;
  localparam logic [2:0] CMD_JUMP   = 3'd3;
  localparam logic [2:0] CMD_LOCK   = 3'd4;
  localparam logic [2:0] CMD_UNLOCK = 3'd5;
  localparam logic [2:0] CMD_HOME   = 3'd6;
  localparam logic [2:0] CMD_RSVD   = 3'd7;

  localparam logic [STATE_W-1:0] S_HOME = '0;
  localparam logic [STATE_W-1:0] S_LAST = STATE_W'(NUM_STATES - 1);
  // One extra bit so NUM_STATES == 2**STATE_W is representable.
  localparam logic [STATE_W:0]   NS_C   = (STATE_W + 1)'(NUM_STATES);
  localparam logic [7:0]         TO_C   = 8'(TIMEOUT);

  logic [STATE_W-1:0] state_q, state_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         idle_q, idle_d;

  logic               illegal;
  logic               tgt_ok;
  logic [7:0]         idle_inc;

  assign illegal  = ({1'b0, state_q} >= NS_C);
  assign tgt_ok   = ({1'b0, jump_target} < NS_C);
  assign idle_inc = (idle_q == TO_C) ? idle_q : idle_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    idle_d    = cmd_valid ? 8'd0 : idle_inc;
    // Priority: illegal-state recovery, then commands, then idle timeout.
    if (illegal) begin
      state_d  = S_HOME;
      locked_d = 1'b0;
      err_d    = 1'b1;
    end else if (cmd_valid) begin
      case (cmd)
        CMD_NOP: ;
        CMD_NEXT: begin
          if (locked_q)              err_d   = 1'b1;
          else if (state_q == S_LAST) state_d = S_HOME;
          else                       state_d = state_q + 1'b1;
        end
        CMD_PREV: begin
          if (locked_q)              err_d   = 1'b1;
          else if (state_q == S_HOME) state_d = S_LAST;
          else                       state_d = state_q - 1'b1;
        end
        CMD_JUMP: begin
          if (locked_q || !tgt_ok) err_d   = 1'b1;
          else                     state_d = jump_target;
        end
        CMD_LOCK:   locked_d = 1'b1;
        CMD_UNLOCK: locked_d = 1'b0;
        CMD_HOME: begin
          if (locked_q) err_d   = 1'b1;
          else          state_d = S_HOME;
        end
        CMD_RSVD: err_d = 1'b1;
        default:  err_d = 1'b1;
      endcase
    end else if ((idle_inc == TO_C) && (state_q != S_HOME) && !locked_q) begin
      state_d   = S_HOME;
      timeout_d = 1'b1;
      idle_d    = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_HOME;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      idle_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      idle_q    <= idle_d;
    end
  end

  // Output is a pure function of the mode register.
  always_comb begin
    out                = '0;
    out[STATE_W-1:0]   = state_q;
  end

  assign state   = state_q;
  assign locked  = locked_q;
  assign err     = err_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mode_seq_fsm.sv
module tb_mode_seq_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [1:0] jump_target;

  logic [2:0] a_out, b_out;
  logic [1:0] a_state, b_state;
  logic       a_locked, b_locked, a_err, b_err, a_to, b_to;

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 -> dut_a (4 modes, timeout 15), 1 -> dut_b (3 modes, timeout 5)
  int m_state[2], m_locked[2], m_idle[2], m_err[2], m_to[2];
  int ns[2]  = '{4, 3};
  int tmo[2] = '{15, 5};

  always #5 clk = ~clk;

  mode_seq_fsm #(.STATE_W(2), .NUM_STATES(4), .OUT_W(3), .TIMEOUT(15)) dut_a (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .jump_target(jump_target),
    .out(a_out), .state(a_state), .locked(a_locked), .err(a_err), .timeout(a_to));

  mode_seq_fsm #(.STATE_W(2), .NUM_STATES(3), .OUT_W(3), .TIMEOUT(5)) dut_b (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .jump_target(jump_target),
    .out(b_out), .state(b_state), .locked(b_locked), .err(b_err), .timeout(b_to));

  function automatic void model_step(int k);
    int idle_next;
    idle_next = (m_idle[k] + 1 > tmo[k]) ? tmo[k] : m_idle[k] + 1;
    m_err[k] = 0;
    m_to[k]  = 0;
    if (rst) begin
      m_state[k] = 0; m_locked[k] = 0; m_idle[k] = 0;
    end else if (m_state[k] >= ns[k]) begin
      m_state[k] = 0; m_locked[k] = 0; m_err[k] = 1;
      m_idle[k] = cmd_valid ? 0 : idle_next;
    end else if (cmd_valid) begin
      m_idle[k] = 0;
      case (int'(cmd))
        1, 2, 6: begin
          if (m_locked[k] != 0) m_err[k] = 1;
          else if (cmd == 3'd1) m_state[k] = (m_state[k] + 1) % ns[k];
          else if (cmd == 3'd2) m_state[k] = (m_state[k] + ns[k] - 1) % ns[k];
          else m_state[k] = 0;
        end
        3: begin
          if (m_locked[k] != 0 || int'(jump_target) >= ns[k]) m_err[k] = 1;
          else m_state[k] = int'(jump_target);
        end
        4: m_locked[k] = 1;
        5: m_locked[k] = 0;
        7: m_err[k] = 1;
        default: ;
      endcase
    end else begin
      m_idle[k] = idle_next;
      if (m_idle[k] == tmo[k] && m_state[k] != 0 && m_locked[k] == 0) begin
        m_state[k] = 0; m_to[k] = 1; m_idle[k] = 0;
      end
    end
  endfunction

  // Drive a command for one cycle, advance the model, return at the falling edge.
  task automatic tick(input logic v, input logic [2:0] c, input logic [1:0] t);
    cmd_valid = v; cmd = c; jump_target = t;
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b1, 3'd1, 2'd0);
    tick(1'b1, 3'd1, 2'd0);
    checks++; if (a_state !== 2'd0)  begin errors++; $display("FAIL reset_state got %0d want 0", a_state); end
    checks++; if (a_out !== 3'd0)    begin errors++; $display("FAIL reset_out got %0d want 0", a_out); end
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", a_locked); end
    checks++; if (a_err !== 1'b0 || a_to !== 1'b0) begin errors++; $display("FAIL reset_pulses got err=%b to=%b want 0", a_err, a_to); end
    rst = 1'b0;
  endtask

  task automatic test_next();
    logic [1:0] exp_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 3'd1, 2'd0);
      checks++; if (a_state !== exp_seq[i]) begin errors++; $display("FAIL next_state[%0d] got %0d want %0d", i, a_state, exp_seq[i]); end
      checks++; if (a_out !== {1'b0, exp_seq[i]}) begin errors++; $display("FAIL next_out[%0d] got %0d want %0d", i, a_out, exp_seq[i]); end
      checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL next_err[%0d] got %b want 0", i, a_err); end
    end
  endtask

  task automatic test_prev_jump();
    tick(1'b1, 3'd2, 2'd0);
    checks++; if (a_state !== 2'd3) begin errors++; $display("FAIL prev_wrap got %0d want 3", a_state); end
    tick(1'b1, 3'd3, 2'd2);
    checks++; if (a_state !== 2'd2) begin errors++; $display("FAIL jump2 got %0d want 2", a_state); end
    checks++; if (b_state !== 2'd2) begin errors++; $display("FAIL b_jump2 got %0d want 2", b_state); end
    tick(1'b1, 3'd3, 2'd3);
    checks++; if (b_state !== 2'd2 || b_err !== 1'b1) begin errors++; $display("FAIL b_jump_bad got state=%0d err=%b want 2/1", b_state, b_err); end
    checks++; if (a_state !== 2'd3 || a_err !== 1'b0) begin errors++; $display("FAIL a_jump3 got state=%0d err=%b want 3/0", a_state, a_err); end
    tick(1'b1, 3'd0, 2'd0);
    checks++; if (b_err !== 1'b0 || b_state !== 2'd2) begin errors++; $display("FAIL b_err_once got err=%b state=%0d want 0/2", b_err, b_state); end
  endtask

  task automatic test_lock();
    tick(1'b1, 3'd6, 2'd0);
    tick(1'b1, 3'd1, 2'd0);
    tick(1'b1, 3'd4, 2'd0);
    checks++; if (a_locked !== 1'b1 || a_state !== 2'd1) begin errors++; $display("FAIL lock_set got locked=%b state=%0d want 1/1", a_locked, a_state); end
    tick(1'b1, 3'd1, 2'd0);
    checks++; if (a_state !== 2'd1 || a_err !== 1'b1) begin errors++; $display("FAIL lock_next got state=%0d err=%b want 1/1", a_state, a_err); end
    tick(1'b1, 3'd5, 2'd0);
    checks++; if (a_locked !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL unlock got locked=%b err=%b want 0/0", a_locked, a_err); end
    tick(1'b1, 3'd1, 2'd0);
    checks++; if (a_state !== 2'd2 || a_locked !== 1'b0) begin errors++; $display("FAIL unlock_next got state=%0d locked=%b want 2/0", a_state, a_locked); end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    for (int i = 1; i <= 15; i++) begin
      tick(1'b0, 3'd0, 2'd0);
      if (a_to === 1'b1) pulses++;
      if (i < 15) begin
        checks++; if (a_state !== 2'd2) begin errors++; $display("FAIL idle_hold[%0d] got %0d want 2", i, a_state); end
      end
    end
    checks++; if (a_state !== 2'd0 || a_to !== 1'b1) begin errors++; $display("FAIL timeout_fire got state=%0d to=%b want 0/1", a_state, a_to); end
    tick(1'b0, 3'd0, 2'd0);
    if (a_to === 1'b1) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_single got %0d pulses want 1", pulses); end
    tick(1'b1, 3'd1, 2'd0);
    tick(1'b1, 3'd1, 2'd0);
    tick(1'b1, 3'd4, 2'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 3'd0, 2'd0);
      if (a_to === 1'b1 || a_state !== 2'd2) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL timeout_locked got %0d bad cycles want 0", pulses); end
    tick(1'b1, 3'd5, 2'd0);
  endtask

  task automatic test_illegal();
    tick(1'b1, 3'd4, 2'd0);
    force dut_b.state_q = 2'd3;
    #1 release dut_b.state_q;
    m_state[1] = 3;
    tick(1'b1, 3'd1, 2'd0);
    checks++; if (b_state !== 2'd0 || b_locked !== 1'b0 || b_err !== 1'b1) begin errors++; $display("FAIL illegal_recover got state=%0d locked=%b err=%b want 0/0/1", b_state, b_locked, b_err); end
    tick(1'b0, 3'd0, 2'd0);
    checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL illegal_err_once got %b want 0", b_err); end
    tick(1'b1, 3'd5, 2'd0);
  endtask

  task automatic test_rst_locked();
    tick(1'b1, 3'd6, 2'd0);
    tick(1'b1, 3'd2, 2'd0);
    tick(1'b1, 3'd4, 2'd0);
    checks++; if (a_state !== 2'd3 || a_locked !== 1'b1) begin errors++; $display("FAIL pre_rst got state=%0d locked=%b want 3/1", a_state, a_locked); end
    rst = 1'b1;
    tick(1'b1, 3'd1, 2'd0);
    rst = 1'b0;
    checks++; if (a_state !== 2'd0 || a_locked !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL rst_locked got state=%0d locked=%b err=%b want 0/0/0", a_state, a_locked, a_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      tick(($urandom_range(0, 99) < 55), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      checks++; if (a_state !== 2'(m_state[0]) || a_out !== 3'(m_state[0]) || a_locked !== 1'(m_locked[0]) || a_err !== 1'(m_err[0]) || a_to !== 1'(m_to[0]))
        begin errors++; $display("FAIL rand_a[%0d] got st=%0d out=%0d lk=%b err=%b to=%b want %0d/%0d/%0d/%0d/%0d", i, a_state, a_out, a_locked, a_err, a_to, m_state[0], m_state[0], m_locked[0], m_err[0], m_to[0]); end
      checks++; if (b_state !== 2'(m_state[1]) || b_out !== 3'(m_state[1]) || b_locked !== 1'(m_locked[1]) || b_err !== 1'(m_err[1]) || b_to !== 1'(m_to[1]))
        begin errors++; $display("FAIL rand_b[%0d] got st=%0d out=%0d lk=%b err=%b to=%b want %0d/%0d/%0d/%0d/%0d", i, b_state, b_out, b_locked, b_err, b_to, m_state[1], m_state[1], m_locked[1], m_err[1], m_to[1]); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; cmd = 3'd0; cmd_valid = 1'b0; jump_target = 2'd0;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_locked[k] = 0; m_idle[k] = 0; m_err[k] = 0; m_to[k] = 0;
    end
    @(negedge clk);
    test_reset();
    test_next();
    test_prev_jump();
    test_lock();
    test_timeout();
    test_illegal();
    test_rst_locked();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_seq_fsm.md
MODE_SEQ_FSM -- requirements
Module: mode_seq_fsm

Interface
REQ-001 SHALL have parameter STATE_W, default 2, giving the width of the state encoding.
REQ-002 SHALL have parameter NUM_STATES, default 4, giving the number of legal states (2 <= NUM_STATES <= 2**STATE_W).
REQ-003 SHALL have parameter OUT_W, default 3, giving the output width (OUT_W >= STATE_W).
REQ-004 SHALL have parameter TIMEOUT, default 15, giving the idle cycles before auto-return (1..255).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port cmd, input, 3 bits: command code; sampled only when cmd_valid=1.
REQ-008 SHALL have port cmd_valid, input, 1 bit: qualifies cmd.
REQ-009 SHALL have port jump_target, input, STATE_W bits: destination for JUMP; sampled with cmd.
REQ-010 SHALL have port out, output, OUT_W bits: Moore output, the current state zero-extended.
REQ-011 SHALL have port state, output, STATE_W bits: the current state register.
REQ-012 SHALL have port locked, output, 1 bit: high while the lock flag is set.
REQ-013 SHALL have port err, output, 1 bit: a registered one-cycle pulse flagging a rejected command or illegal-state recovery.
REQ-014 SHALL have port timeout, output, 1 bit: a registered one-cycle pulse flagging an idle auto-return.

Function
REQ-015 SHALL decode cmd as follows: 0 NOP, 1 NEXT, 2 PREV, 3 JUMP, 4 LOCK, 5 UNLOCK, 6 HOME, 7 reserved.
REQ-016 SHALL apply a valid command on the clock edge at which it is sampled; state and out update one cycle after sampling.
REQ-017 NEXT SHALL move to state+1, wrapping from NUM_STATES-1 to 0.
REQ-018 PREV SHALL move to state-1, wrapping from 0 to NUM_STATES-1.
REQ-019 JUMP SHALL move to jump_target if jump_target < NUM_STATES; otherwise the state is unchanged and err pulses.
REQ-020 LOCK SHALL set the lock flag; while locked, NEXT, PREV, JUMP and HOME are ignored, the state holds, and err pulses.
REQ-021 UNLOCK SHALL clear the lock flag; UNLOCK while already unlocked is a NOP with no err.
REQ-022 LOCK while already locked SHALL be a NOP with no err.
REQ-023 HOME SHALL move to state 0.
REQ-024 Reserved code 7 SHALL leave the state and lock flag unchanged and pulse err.
REQ-025 A NOP, or cmd_valid=0, SHALL hold the state.
REQ-026 SHALL keep an idle counter that clears on any cycle with cmd_valid=1 and otherwise increments, saturating at TIMEOUT.
REQ-027 When the idle counter reaches TIMEOUT, with state != 0 and unlocked, SHALL move to state 0, pulse timeout, and clear the counter.
REQ-028 While locked, or while in state 0, SHALL NOT apply a timeout, and SHALL NOT pulse timeout.
REQ-029 If the state register holds a value >= NUM_STATES (upset or unused encoding), SHALL move to state 0, clear the lock flag, and pulse err on the next edge, regardless of cmd.
REQ-030 Illegal-state recovery (REQ-029) SHALL take priority over commands, and commands SHALL take priority over timeout.
REQ-031 SHALL drive out as a function of the state register only; it SHALL NOT depend combinationally on cmd.
REQ-032 Every case statement SHALL cover all 2**STATE_W encodings, with no latches and no unreachable lock-up states.

Reset
REQ-033 On rst=1 at a clock edge, SHALL set state=0, out=0, locked=0, err=0, timeout=0, and idle counter=0.
REQ-034 rst SHALL override any command presented in the same cycle.
REQ-035 rst SHALL clear the lock flag when asserted mid-operation.

Verification
REQ-036 With reset deasserted, drive four NEXT commands -> state sequences 1,2,3,0, out tracks it, and err=0 throughout.
REQ-037 From state 0, drive PREV; then JUMP with target 2 -> state=3, then state=2; with NUM_STATES=3, a JUMP to 3 -> state stays put and err pulses once.
REQ-038 Drive LOCK, then NEXT, then UNLOCK, then NEXT from state 1 -> state stays 1 with err pulsed on the NEXT, then state becomes 2 with locked=0.
REQ-039 From state 2, hold cmd_valid=0 for TIMEOUT cycles -> state=0 with a single timeout pulse; repeat while locked -> no transition.
REQ-040 With NUM_STATES=3, force the state register to 3 -> the next edge gives state=0, locked=0, and err=1 for one cycle.
REQ-041 Assert rst while locked in state 3 with NEXT applied -> state=0, locked=0, no err.
